// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_divider
//  Purpose  : Sequential unsigned restoring divider, one quotient bit per
//             clock. Remainder/quotient pair shifts left each iteration, the
//             divisor is trial-subtracted and the quotient bit enters the LSB.
//  Revision : 1.0  initial release
// ============================================================================
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             div_by_zero_o
);

   localparam int             CW        = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             dbz_q, dbz_d;

   // Trial value and difference carry one extra bit so a shifted-out
   // remainder MSB still takes part in the compare.
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             fits;

   assign trial = {r_q, q_q[WIDTH-1]};
   assign diff  = trial - {1'b0, d_q};
   assign fits  = (trial >= {1'b0, d_q});

   // State register and datapath registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         cnt_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         r_q     <= r_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         dbz_q   <= dbz_d;
      end
   end

   // Next-state logic: accept starts in IDLE/DONE, iterate in RUN.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      r_d     = r_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dbz_d   = dbz_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start_i) begin
               cnt_d = '0;
               if (divisor_i != '0) begin
                  q_d     = dividend_i;
                  r_d     = '0;
                  d_d     = divisor_i;
                  dbz_d   = 1'b0;
                  state_d = S_RUN;
               end else begin
                  // Zero divisor skips the iteration entirely.
                  q_d     = '1;
                  r_d     = dividend_i;
                  d_d     = '0;
                  dbz_d   = 1'b1;
                  state_d = S_DONE;
               end
            end else if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
         end

         S_RUN: begin
            if (fits) begin
               r_d = diff[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b1};
            end else begin
               r_d = trial[WIDTH-1:0];
               q_d = {q_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
               state_d = S_DONE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign quotient_o    = q_q;
   assign remainder_o   = r_q;
   assign busy_o        = (state_q == S_RUN);
   assign done_o        = (state_q == S_DONE);
   assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_divider
//  Purpose  : Self-checking bench for seq_divider with an expected-result
//             queue filled at start and drained at done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start_i = 1'b0;
   logic [W-1:0] dividend_i = '0;
   logic [W-1:0] divisor_i = '0;
   logic [W-1:0] quotient_o;
   logic [W-1:0] remainder_o;
   logic         busy_o;
   logic         done_o;
   logic         div_by_zero_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
   } exp_t;

   exp_t sb[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start_i),
      .dividend_i    (dividend_i),
      .divisor_i     (divisor_i),
      .quotient_o    (quotient_o),
      .remainder_o   (remainder_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .div_by_zero_o (div_by_zero_o)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
      exp_t e;
      e.q = q;
      e.r = r;
      e.z = z;
      return e;
   endfunction

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == '0) return mk('1, a, 1'b1);
      return mk(a / b, a % b, 1'b0);
   endfunction

   // Drive a one-cycle start; returns #1 after the accepting edge.
   task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
      sb.push_back(e);
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      @(posedge clk);
      #1;
      start_i    = 1'b0;
      dividend_i = $urandom;
      divisor_i  = $urandom;
   endtask

   // Bounded wait for done; counts edges and busy cycles along the way.
   task automatic wait_done(output int edges, output int busy_cycles, output bit ok);
      edges = 0;
      busy_cycles = 0;
      while (!done_o && edges < 3 * W) begin
         if (busy_o) busy_cycles++;
         @(posedge clk);
         #1;
         edges++;
      end
      ok = done_o;
   endtask

   task automatic test_reset();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++;
      if ({quotient_o, remainder_o, busy_o, done_o, div_by_zero_o} !== '0) begin
         failures++;
         $display("FAIL reset_values: got q=%h r=%h busy=%b done=%b dbz=%b expected all zero",
                  quotient_o, remainder_o, busy_o, done_o, div_by_zero_o);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_done: cycle %0d got done=%b expected 0", i, done_o);
         end
      end
   endtask

   task automatic test_basic();
      int   e, b;
      bit   ok;
      exp_t x;
      start_div(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || e != W) begin
         failures++;
         $display("FAIL basic_latency: got done after %0d edges (ok=%b) expected %0d", e, ok, W);
      end
      checks++;
      if (b != W) begin
         failures++;
         $display("FAIL basic_busy: got %0d busy cycles expected %0d", b, W);
      end
      checks++;
      if ({quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL basic_result: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                  quotient_o, remainder_o, div_by_zero_o, x.q, x.r, x.z);
      end
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0 || quotient_o !== x.q || remainder_o !== x.r) begin
         failures++;
         $display("FAIL basic_hold: got done=%b q=%h r=%h expected done=0 q=%h r=%h",
                  done_o, quotient_o, remainder_o, x.q, x.r);
      end
   endtask

   task automatic test_extremes();
      logic [W-1:0] ta [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5,         32'h8000_0000};
      logic [W-1:0] tb [4] = '{32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 32'd3};
      logic [W-1:0] tq [4] = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'h2AAA_AAAA};
      logic [W-1:0] tr [4] = '{32'd0,         32'd0,         32'd5,         32'd2};
      int   e, b;
      bit   ok;
      exp_t x;
      for (int i = 0; i < 4; i++) begin
         start_div(ta[i], tb[i], mk(tq[i], tr[i], 1'b0));
         wait_done(e, b, ok);
         x = sb.pop_front();
         checks++;
         if (!ok || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
            failures++;
            $display("FAIL extreme_%0d: got ok=%b q=%h r=%h z=%b expected q=%h r=%h z=%b",
                     i, ok, quotient_o, remainder_o, div_by_zero_o, x.q, x.r, x.z);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div_zero();
      int   e, b;
      bit   ok;
      exp_t x;
      start_div(32'd1234, 32'd0, mk(32'hFFFF_FFFF, 32'd1234, 1'b1));
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0) begin
         failures++;
         $display("FAIL dbz_timing: got done=%b busy=%b expected done=1 busy=0", done_o, busy_o);
      end
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || e != 0 || b != 0 || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL dbz_result: got edges=%0d busy=%0d q=%h r=%h z=%b expected edges=0 busy=0 q=%h r=%h z=%b",
                  e, b, quotient_o, remainder_o, div_by_zero_o, x.q, x.r, x.z);
      end
      @(posedge clk); #1;
      checks++;
      if (done_o !== 1'b0 || div_by_zero_o !== 1'b1) begin
         failures++;
         $display("FAIL dbz_hold: got done=%b dbz=%b expected done=0 dbz=1", done_o, div_by_zero_o);
      end
   endtask

   task automatic test_ignore_start();
      int   e, b;
      bit   ok;
      exp_t x;
      start_div(32'd100, 32'd7, mk(32'd14, 32'd2, 1'b0));
      repeat (10) begin @(posedge clk); #1; end
      dividend_i = 32'd50;
      divisor_i  = 32'd6;
      start_i    = 1'b1;
      @(posedge clk); #1;
      start_i    = 1'b0;
      checks++;
      if (busy_o !== 1'b1) begin
         failures++;
         $display("FAIL ignore_busy: got busy=%b expected 1", busy_o);
      end
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || e != W - 11 || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL ignore_result: got edges=%0d q=%h r=%h z=%b expected edges=%0d q=%h r=%h z=%b",
                  e, quotient_o, remainder_o, div_by_zero_o, W - 11, x.q, x.r, x.z);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int   e, b;
      bit   ok;
      exp_t x;
      start_div(32'h8000_0000, 32'd3, mk(32'h2AAA_AAAA, 32'd2, 1'b0));
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL b2b_first: got ok=%b q=%h r=%h expected q=%h r=%h", ok, quotient_o, remainder_o, x.q, x.r);
      end
      start_div(32'd50, 32'd6, mk(32'd8, 32'd2, 1'b0));
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
         failures++;
         $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", busy_o, done_o);
      end
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || e != W || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL b2b_second: got edges=%0d q=%h r=%h z=%b expected edges=%0d q=%h r=%h z=%b",
                  e, quotient_o, remainder_o, div_by_zero_o, W, x.q, x.r, x.z);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      int   e, b;
      bit   ok;
      exp_t x;
      start_div(32'hFFFF_FFFF, 32'd1, mk(32'hFFFF_FFFF, 32'd0, 1'b0));
      repeat (16) begin @(posedge clk); #1; end
      #3;
      rst_n = 1'b0;
      #1;
      void'(sb.pop_back());
      checks++;
      if ({quotient_o, remainder_o, busy_o, done_o, div_by_zero_o} !== '0) begin
         failures++;
         $display("FAIL abort_async: got q=%h r=%h busy=%b done=%b dbz=%b expected all zero",
                  quotient_o, remainder_o, busy_o, done_o, div_by_zero_o);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < W; i++) begin
         @(posedge clk); #1;
         checks++;
         if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL abort_quiet: cycle %0d got done=%b busy=%b expected 0 0", i, done_o, busy_o);
         end
      end
      start_div(32'd9, 32'd4, mk(32'd2, 32'd1, 1'b0));
      wait_done(e, b, ok);
      x = sb.pop_front();
      checks++;
      if (!ok || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
         failures++;
         $display("FAIL abort_recover: got ok=%b q=%h r=%h z=%b expected q=%h r=%h z=%b",
                  ok, quotient_o, remainder_o, div_by_zero_o, x.q, x.r, x.z);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int           e, b;
      bit           ok;
      exp_t         x;
      logic [W-1:0] a, d;
      for (int n = 0; n < 1000; n++) begin
         a = $urandom;
         case ($urandom_range(0, 5))
            0:       d = '0;
            1:       d = $urandom_range(1, 16);
            2:       d = $urandom >> $urandom_range(0, 31);
            3:       d = a;
            4:       begin a = a >> $urandom_range(0, 31); d = $urandom; end
            default: d = $urandom;
         endcase
         start_div(a, d, model(a, d));
         wait_done(e, b, ok);
         x = sb.pop_front();
         checks++;
         if (!ok || {quotient_o, remainder_o, div_by_zero_o} !== x) begin
            failures++;
            $display("FAIL random_%0d: a=%h d=%h got ok=%b q=%h r=%h z=%b expected q=%h r=%h z=%b",
                     n, a, d, ok, quotient_o, remainder_o, div_by_zero_o, x.q, x.r, x.z);
         end
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk); #1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_ignore_start();
      test_back_to_back();
      test_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
